// File: rtl/aexm_dmem_seq.sv
// Load/store sequencer between the AEXM execute stage and the data cache port.
// Runs one strobe/ack bus cycle per sized access and reports done/error/timeout.
`timescale 1ns/1ps
module aexm_dmem_seq #(
  parameter int TMO_W  = 8,
  parameter bit TMO_EN = 1'b1
) (
  input  logic        gclk,
  input  logic        grst_n,
  input  logic        lsu_req,
  input  logic        lsu_we,
  input  logic [1:0]  lsu_size,
  input  logic [31:0] lsu_addr,
  input  logic [31:0] lsu_wdat,
  output logic        lsu_busy,
  output logic        lsu_done,
  output logic        lsu_err,
  output logic [31:0] lsu_rdat,
  output logic [3:0]  rDWBSEL,
  output logic        dc_stb,
  output logic        dc_we,
  output logic [29:0] dc_adr,
  output logic [3:0]  dc_sel,
  output logic [31:0] dc_dato,
  input  logic [31:0] dc_dati,
  input  logic        dc_ack,
  input  logic        dc_err,
  output logic [1:0]  dbgState
);

  // Handshake: lsu_req is taken only while IDLE; lsu_busy stalls the core until the
  // access resolves, and exactly one of lsu_done/lsu_err pulses per accepted request.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUS  = 2'd1,
    DONE = 2'd2,
    ERR  = 2'd3
  } state_t;

  state_t           state;
  state_t           stateNext;
  logic [3:0]       laneSel;
  logic             misalign;
  logic             accept;
  logic [TMO_W-1:0] tmoCnt;
  logic [TMO_W-1:0] tmoNext;
  logic             tmoHit;

  // Big-endian lane map: lowest address byte sits in lane 3.
  always_comb begin
    laneSel  = 4'h0;
    misalign = 1'b0;
    case (lsu_size)
      2'd0: laneSel = 4'b1000 >> lsu_addr[1:0];
      2'd1: begin
        laneSel  = lsu_addr[1] ? 4'h3 : 4'hC;
        misalign = lsu_addr[0];
      end
      2'd2: begin
        laneSel  = 4'hF;
        misalign = |lsu_addr[1:0];
      end
      default: misalign = 1'b1;
    endcase
  end

  // The counter reaches all-ones on the edge that leaves BUS for a timeout.
  assign tmoNext = tmoCnt + TMO_W'(1);
  assign tmoHit  = TMO_EN && (&tmoNext);
  assign accept  = (state == IDLE) && lsu_req && !misalign;

  always_comb begin
    stateNext = state;
    case (state)
      IDLE: if (lsu_req) stateNext = misalign ? ERR : BUS;
      BUS: begin
        if (dc_err)      stateNext = ERR;
        else if (dc_ack) stateNext = DONE;
        else if (tmoHit) stateNext = ERR;
      end
      DONE:    stateNext = IDLE;
      ERR:     stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
  end

  always_ff @(posedge gclk or negedge grst_n) begin
    if (!grst_n) state <= IDLE;
    else         state <= stateNext;
  end

  always_ff @(posedge gclk or negedge grst_n) begin
    if (!grst_n) begin
      dc_adr   <= '0;
      dc_sel   <= '0;
      dc_we    <= 1'b0;
      dc_dato  <= '0;
      rDWBSEL  <= '0;
      lsu_rdat <= '0;
      tmoCnt   <= '0;
    end else if (accept) begin
      dc_adr  <= lsu_addr[31:2];
      dc_sel  <= laneSel;
      dc_we   <= lsu_we;
      dc_dato <= lsu_we ? lsu_wdat : 32'h0;
      rDWBSEL <= laneSel;
      tmoCnt  <= '0;
    end else if (state == BUS) begin
      tmoCnt <= tmoNext;
      if (dc_ack && !dc_err && !dc_we) lsu_rdat <= dc_dati;
    end
  end

  // Strobe decodes the registered state, so reset drops it asynchronously.
  assign dc_stb   = (state == BUS);
  assign lsu_done = (state == DONE);
  assign lsu_err  = (state == ERR);
  assign lsu_busy = (state == BUS) || ((state == IDLE) && lsu_req);
  assign dbgState = state;

endmodule

// File: tb/tb_aexm_dmem_seq.sv
// Self-checking bench for aexm_dmem_seq: directed scenarios followed by random
// accesses scored against a transaction-level model of lanes, latency and timeout.
`timescale 1ns/1ps
module tb_aexm_dmem_seq;

  localparam int TMO_W    = 4;
  localparam int TMO_LIM  = (1 << TMO_W) - 1;

  logic        gclk = 1'b0;
  logic        grst_n;
  logic        lsu_req;
  logic        lsu_we;
  logic [1:0]  lsu_size;
  logic [31:0] lsu_addr;
  logic [31:0] lsu_wdat;
  logic        lsu_busy;
  logic        lsu_done;
  logic        lsu_err;
  logic [31:0] lsu_rdat;
  logic [3:0]  rDWBSEL;
  logic        dc_stb;
  logic        dc_we;
  logic [29:0] dc_adr;
  logic [3:0]  dc_sel;
  logic [31:0] dc_dato;
  logic [31:0] dc_dati;
  logic        dc_ack;
  logic        dc_err;
  logic [1:0]  dbgState;

  int checks   = 0;
  int failures = 0;

  logic [31:0] exp_q[$];
  logic [31:0] cur_rdat;
  logic [3:0]  exp_dwbsel;

  aexm_dmem_seq #(.TMO_W(TMO_W), .TMO_EN(1'b1)) dut (
    .gclk(gclk), .grst_n(grst_n),
    .lsu_req(lsu_req), .lsu_we(lsu_we), .lsu_size(lsu_size),
    .lsu_addr(lsu_addr), .lsu_wdat(lsu_wdat),
    .lsu_busy(lsu_busy), .lsu_done(lsu_done), .lsu_err(lsu_err),
    .lsu_rdat(lsu_rdat), .rDWBSEL(rDWBSEL),
    .dc_stb(dc_stb), .dc_we(dc_we), .dc_adr(dc_adr), .dc_sel(dc_sel),
    .dc_dato(dc_dato), .dc_dati(dc_dati), .dc_ack(dc_ack), .dc_err(dc_err),
    .dbgState(dbgState)
  );

  // clock / reset
  always #5 gclk = ~gclk;

  initial begin
    #2000000;
    $display("FAIL watchdog obs=running exp=finished");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s obs=%h exp=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge gclk);
    #1;
  endtask

  task automatic idle_inputs();
    lsu_req  = 1'b0;
    lsu_we   = 1'b0;
    lsu_size = 2'd0;
    lsu_addr = 32'h0;
    lsu_wdat = 32'h0;
    dc_ack   = 1'b0;
    dc_err   = 1'b0;
  endtask

  // One access. waits = wait cycles before the response; respond=0 means no response.
  task automatic run_txn(input bit we, input logic [1:0] size, input logic [31:0] addr,
                         input logic [31:0] wdat, input int waits, input bit respond,
                         input bit use_err, input bit both, input logic [31:0] rdata);
    int unsigned nb;
    int unsigned lowb;
    bit          mis;
    logic [3:0]  sel;
    int          r;
    bit          ended;
    bit          exp_err;
    int          j;

    lowb = int'(addr[1:0]);
    nb   = (size == 2'd3) ? 0 : (1 << size);
    mis  = (size == 2'd3) || ((lowb % nb) != 0);
    sel  = mis ? 4'h0 : 4'(((1 << nb) - 1) << (4 - nb - lowb));
    r    = respond ? waits + 1 : TMO_LIM + 100;

    // request cycle
    lsu_req  = 1'b1;
    lsu_we   = we;
    lsu_size = size;
    lsu_addr = addr;
    lsu_wdat = wdat;
    #1;
    chk("req_busy", 32'(lsu_busy), 32'd1);
    chk("req_nostb", 32'(dc_stb), 32'd0);
    tick();
    idle_inputs();

    if (mis) begin
      #1;
      chk("mis_err", 32'(lsu_err), 32'd1);
      chk("mis_done", 32'(lsu_done), 32'd0);
      chk("mis_nostb", 32'(dc_stb), 32'd0);
      chk("mis_busy", 32'(lsu_busy), 32'd0);
      chk("mis_dwbsel", 32'(rDWBSEL), 32'(exp_dwbsel));
      tick();
      chk("mis_err_pulse", 32'(lsu_err), 32'd0);
      return;
    end

    exp_dwbsel = sel;
    exp_err    = 1'b0;
    ended      = 1'b0;
    j          = 1;
    while (!ended && j < 100) begin
      dc_dati = $urandom;
      if (j == r) begin
        dc_dati = rdata;
        dc_ack  = !use_err || both;
        dc_err  = use_err;
        exp_err = use_err;
        ended   = 1'b1;
        if (!use_err && !we) exp_q.push_back(rdata);
      end else if (j == TMO_LIM) begin
        exp_err = 1'b1;
        ended   = 1'b1;
      end
      #1;
      chk("bus_stb", 32'(dc_stb), 32'd1);
      chk("bus_busy", 32'(lsu_busy), 32'd1);
      chk("bus_adr", 32'(dc_adr), addr >> 2);
      chk("bus_sel", 32'(dc_sel), 32'(sel));
      chk("bus_we", 32'(dc_we), 32'(we));
      chk("bus_dato", dc_dato, we ? wdat : 32'h0);
      chk("bus_dwbsel", 32'(rDWBSEL), 32'(sel));
      tick();
      dc_ack = 1'b0;
      dc_err = 1'b0;
      j++;
    end
    if (!ended) chk("bus_bound", 32'd0, 32'd1);

    #1;
    if (exp_q.size() > 0) cur_rdat = exp_q.pop_front();
    chk("end_done", 32'(lsu_done), 32'(!exp_err));
    chk("end_err", 32'(lsu_err), 32'(exp_err));
    chk("end_stb", 32'(dc_stb), 32'd0);
    chk("end_busy", 32'(lsu_busy), 32'd0);
    chk("end_rdat", lsu_rdat, cur_rdat);
    chk("end_dwbsel", 32'(rDWBSEL), 32'(exp_dwbsel));
    tick();
    chk("pulse_done", 32'(lsu_done), 32'd0);
    chk("pulse_err", 32'(lsu_err), 32'd0);
    chk("hold_rdat", lsu_rdat, cur_rdat);
  endtask

  // Bus responses outside BUS must not start or finish anything.
  task automatic stray_response();
    dc_ack  = 1'b1;
    dc_err  = ($urandom_range(0, 1) == 1);
    dc_dati = $urandom;
    tick();
    dc_ack = 1'b0;
    dc_err = 1'b0;
    chk("stray_done", 32'(lsu_done), 32'd0);
    chk("stray_err", 32'(lsu_err), 32'd0);
    chk("stray_stb", 32'(dc_stb), 32'd0);
    chk("stray_rdat", lsu_rdat, cur_rdat);
  endtask

  initial begin
    idle_inputs();
    dc_dati    = 32'h0;
    cur_rdat   = 32'h0;
    exp_dwbsel = 4'h0;
    grst_n     = 1'b0;
    repeat (3) @(posedge gclk);
    #1;
    chk("rst_stb", 32'(dc_stb), 32'd0);
    chk("rst_busy", 32'(lsu_busy), 32'd0);
    chk("rst_done", 32'(lsu_done), 32'd0);
    chk("rst_err", 32'(lsu_err), 32'd0);
    chk("rst_rdat", lsu_rdat, 32'h0);
    chk("rst_dwbsel", 32'(rDWBSEL), 32'h0);
    chk("rst_adr", 32'(dc_adr), 32'h0);
    chk("rst_sel", 32'(dc_sel), 32'h0);
    chk("rst_dato", dc_dato, 32'h0);
    chk("rst_we", 32'(dc_we), 32'h0);
    @(negedge gclk);
    grst_n = 1'b1;
    tick();

    // word load, zero-wait ack
    run_txn(1'b0, 2'd2, 32'h0000_0100, 32'h0, 0, 1'b1, 1'b0, 1'b0, 32'hDEAD_BEEF);
    // byte store after 3 waits
    run_txn(1'b1, 2'd0, 32'h0000_0203, 32'h5A5A_5A5A, 3, 1'b1, 1'b0, 1'b0, 32'h1111_1111);
    chk("store_keeps_rdat", lsu_rdat, 32'hDEAD_BEEF);
    // misaligned half
    run_txn(1'b0, 2'd1, 32'h0000_0101, 32'h0, 0, 1'b1, 1'b0, 1'b0, 32'h0);
    // ack and err together
    run_txn(1'b0, 2'd1, 32'h0000_0102, 32'h0, 1, 1'b1, 1'b1, 1'b1, 32'hCAFE_F00D);
    chk("err_keeps_rdat", lsu_rdat, 32'hDEAD_BEEF);
    // timeout
    run_txn(1'b0, 2'd0, 32'h0000_0007, 32'h0, 0, 1'b0, 1'b0, 1'b0, 32'h0);
    // illegal size
    run_txn(1'b1, 2'd3, 32'h0000_0000, 32'h1234_5678, 0, 1'b1, 1'b0, 1'b0, 32'h0);
    stray_response();

    // reset mid-bus
    lsu_req  = 1'b1;
    lsu_size = 2'd2;
    lsu_addr = 32'h0000_0400;
    tick();
    idle_inputs();
    tick();
    chk("pre_rst_stb", 32'(dc_stb), 32'd1);
    grst_n = 1'b0;
    #1;
    chk("async_rst_stb", 32'(dc_stb), 32'd0);
    chk("async_rst_busy", 32'(lsu_busy), 32'd0);
    chk("async_rst_rdat", lsu_rdat, 32'h0);
    cur_rdat   = 32'h0;
    exp_dwbsel = 4'h0;
    exp_q.delete();
    @(negedge gclk);
    grst_n = 1'b1;
    tick();
    run_txn(1'b0, 2'd1, 32'h0000_0812, 32'h0, 2, 1'b1, 1'b0, 1'b0, 32'h0BAD_F00D);

    // random traffic
    for (int n = 0; n < 200; n++) begin
      logic [31:0] a;
      int          mode;
      a    = $urandom;
      mode = $urandom_range(0, 9);
      run_txn(($urandom_range(0, 1) == 1), 2'($urandom_range(0, 3)), a, $urandom,
              $urandom_range(0, 17), (mode != 9), (mode < 2), (mode == 0), $urandom);
      if ($urandom_range(0, 3) == 0) stray_response();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
